// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C master arbiter slice.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module i2c_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;
  int               cand_i;

  assign any_req = |req;

  // Walk the candidates in priority order; the first hit wins and masks the rest.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    cand_i  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = int'(last) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = IDX_W'(cand_i);
      if (!found && req[cand]) begin
        found         = 1'b1;
        win_oh[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int EN_HOLD_MAX = 8
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_rw,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [I2C_DATA_W-1:0]         rdata,
  output logic                          busy,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_data_in,
  output logic                          m_rw,
  output logic                          m_enable,
  input  logic [I2C_DATA_W-1:0]         m_data_out,
  input  logic                          m_ready
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(EN_HOLD_MAX + 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]     win_oh;
  logic                   any_req;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [I2C_ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [I2C_DATA_W-1:0]  wdata_arr [NUM_REQ];
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0]            wd_cnt;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
    assign wdata_arr[i] = req_wdata[I2C_DATA_W*i +: I2C_DATA_W];
  end

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // done/err are set on the edge entering FINISH so they are visible exactly during FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
      m_enable  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && m_ready) begin
            state     <= LAUNCH;
            gnt       <= win_oh;
            last      <= win_idx;
            m_addr    <= addr_arr[win_idx];
            m_data_in <= wdata_arr[win_idx];
            m_rw      <= req_rw[win_idx];
            m_enable  <= 1'b1;
            busy      <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          hold_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (!m_ready) begin
            m_enable <= 1'b0;
            state    <= WAIT_DONE;
          end else if (hold_cnt == HOLD_W'(EN_HOLD_MAX - 1)) begin
            // Master never acknowledged the enable: give up and report failure.
            m_enable <= 1'b0;
            state    <= FINISH;
            done     <= gnt;
            err      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        WAIT_DONE: begin
          if (m_ready) begin
            if (m_rw) rdata <= m_data_out;
            state <= FINISH;
            done  <= gnt;
          end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
              state <= FINISH;
              done  <= gnt;
              err   <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
`endif
          end
        end
        FINISH: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: behavioural master, per-cycle model compare, directed tests.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int EN_HOLD_MAX = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*7-1:0]  req_addr;
  logic [NUM_REQ*8-1:0]  req_wdata;
  logic [NUM_REQ-1:0]    req_rw = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic [7:0]            rdata;
  logic                  busy;
  logic [6:0]            m_addr;
  logic [7:0]            m_data_in;
  logic                  m_rw;
  logic                  m_enable;
  logic [7:0]            m_data_out = 8'h00;
  logic                  m_ready = 1'b1;

  logic [6:0]            op_addr  [NUM_REQ];
  logic [7:0]            op_wdata [NUM_REQ];

  int                    checks = 0;
  int                    errors = 0;

  bit                    master_stuck = 1'b0;
  int                    master_low   = 3;
  logic [7:0]            master_rdata = 8'h00;

  int                    grant_log [$];

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[7*i +: 7]  = op_addr[i];
      req_wdata[8*i +: 8] = op_wdata[i];
    end
  end

  i2c_master_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .EN_HOLD_MAX (EN_HOLD_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rw     (req_rw),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rw       (m_rw),
    .m_enable   (m_enable),
    .m_data_out (m_data_out),
    .m_ready    (m_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is always at a falling edge; inputs change 1 time unit later.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
    #1 req = r;
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int from);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic wait_grant();
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int idx, output logic got_err, output int en_cycles);
    bit seen = 1'b0;
    got_err   = 1'b0;
    en_cycles = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (m_enable) en_cycles++;
      if (done[idx]) begin
        seen    = 1'b1;
        got_err = err;
      end
    end
    if (!seen) checkOutput($sformatf("done%0d_timeout", idx), 32'd0, 32'd1);
  endtask

  // Behavioural I2C master: acknowledges one cycle after seeing enable, stays busy, returns data.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_enable && m_ready && !master_stuck) begin
        @(negedge clk);
        #1 m_ready = 1'b0;
        repeat (master_low) @(negedge clk);
        #1;
        m_data_out = master_rdata;
        m_ready    = 1'b1;
      end
    end
  end

  // Transaction-level model of the arbiter, compared against the DUT on every falling edge.
  bit                 mdl_active    = 1'b0;
  bit                 mdl_acked     = 1'b0;
  bit                 mdl_post_done = 1'b0;
  int                 mdl_en_cnt    = 0;
  int                 mdl_last      = NUM_REQ - 1;
  logic [NUM_REQ-1:0] exp_gnt       = '0;
  logic [6:0]         exp_addr      = '0;
  logic [7:0]         exp_wdata     = '0;
  logic               exp_rw        = 1'b0;
  logic [7:0]         exp_rdata     = '0;

  always @(negedge clk) begin : compare
    int w;
    if (rst) begin
      checkOutput("rst_ctrl", {gnt, done, err, busy, m_enable, m_rw}, 32'd0);
      checkOutput("rst_data", {m_addr, m_data_in, rdata}, 32'd0);
      mdl_active    = 1'b0;
      mdl_acked     = 1'b0;
      mdl_post_done = 1'b0;
      mdl_last      = NUM_REQ - 1;
      exp_gnt       = '0;
      exp_rdata     = '0;
    end else begin
      if (!mdl_active) begin
        if (mdl_post_done) begin
          checkOutput("finish_exit", {busy, gnt, done, err, m_enable}, 32'd0);
          mdl_post_done = 1'b0;
        end else if ((req != '0) && m_ready) begin
          w         = rr_pick(req, mdl_last);
          mdl_last  = w;
          exp_gnt   = NUM_REQ'(1) << w;
          exp_addr  = op_addr[w];
          exp_wdata = op_wdata[w];
          exp_rw    = req_rw[w];
          grant_log.push_back(w);
          mdl_active = 1'b1;
          mdl_acked  = 1'b0;
          mdl_en_cnt = 1;
          checkOutput("grant", gnt, exp_gnt);
          checkOutput("launch", {m_enable, busy, done, err}, {1'b1, 1'b1, 4'b0000, 1'b0});
          checkOutput("launch_ops", {m_addr, m_data_in, m_rw}, {exp_addr, exp_wdata, exp_rw});
        end else begin
          checkOutput("idle", {busy, gnt, done, err, m_enable}, 32'd0);
        end
      end else begin
        checkOutput("gnt_held", {busy, gnt}, {1'b1, exp_gnt});
        checkOutput("ops_held", {m_addr, m_data_in, m_rw}, {exp_addr, exp_wdata, exp_rw});
        if (!mdl_acked && mdl_en_cnt == 1 + EN_HOLD_MAX) begin
          checkOutput("hold_timeout", {m_enable, done, err}, {1'b0, exp_gnt, 1'b1});
          mdl_active    = 1'b0;
          mdl_post_done = 1'b1;
        end else if (!mdl_acked && !m_ready && mdl_en_cnt >= 2) begin
          mdl_acked = 1'b1;
          checkOutput("ack_drop_en", {m_enable, done, err}, 32'd0);
        end else if (!mdl_acked) begin
          checkOutput("en_hold", {m_enable, done, err}, {1'b1, 4'b0000, 1'b0});
          mdl_en_cnt++;
        end else if (m_ready) begin
          checkOutput("done", {m_enable, done, err}, {1'b0, exp_gnt, 1'b0});
          if (exp_rw) exp_rdata = m_data_out;
          mdl_active    = 1'b0;
          mdl_post_done = 1'b1;
        end else begin
          checkOutput("wait_done", {m_enable, done, err}, 32'd0);
        end
      end
      checkOutput("rdata", rdata, exp_rdata);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic e;
    int   n;
    int   order_rr [5];
    int   order_fr [3];
    order_rr = '{0, 1, 2, 3, 0};
    order_fr = '{1, 3, 1};
    for (int i = 0; i < NUM_REQ; i++) begin
      op_addr[i]  = '0;
      op_wdata[i] = '0;
    end

    repeat (2) @(negedge clk);
    checkOutput("reset_gnt_busy_en", {gnt, busy, m_enable}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'h00);
    #1 rst = 1'b0;

    // Single write from requester 0
    @(negedge clk);
    $display("[TB] single write");
    op_addr[0] = 7'h2A; op_wdata[0] = 8'h06; req_rw[0] = 1'b0;
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("w_gnt", gnt, 32'h1);
    checkOutput("w_en", m_enable, 32'h1);
    checkOutput("w_addr", m_addr, 32'h2A);
    checkOutput("w_wdata", m_data_in, 32'h06);
    wait_done(0, e, n);
    checkOutput("w_err", e, 32'h0);
    applyStimulus(4'b0000);

    // Read from requester 2
    @(negedge clk);
    $display("[TB] read");
    op_addr[2] = 7'h2A; req_rw[2] = 1'b1; master_rdata = 8'hA5;
    applyStimulus(4'b0100);
    wait_done(2, e, n);
    checkOutput("r_rdata_at_done", rdata, 32'hA5);
    checkOutput("r_err", e, 32'h0);
    applyStimulus(4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("r_rdata_hold", rdata, 32'hA5);

    // Serve requester 3 so the pointer sits at 3
    op_addr[3] = 7'h13; op_wdata[3] = 8'h33; req_rw[3] = 1'b0;
    applyStimulus(4'b1000);
    wait_done(3, e, n);
    applyStimulus(4'b0000);

    // Contention: all four held
    @(negedge clk);
    $display("[TB] contention");
    for (int i = 0; i < NUM_REQ; i++) begin
      op_addr[i]  = 7'h10 + 7'(i);
      op_wdata[i] = 8'hC0 + 8'(i);
      req_rw[i]   = 1'b0;
    end
    grant_log.delete();
    applyStimulus(4'b1111);
    wait_grant();
    #1 op_addr[0] = 7'h55;
    for (int t = 0; t < 5; t++) wait_done(order_rr[t], e, n);
    applyStimulus(4'b0000);
    checkOutput("rr_count", grant_log.size(), 32'd5);
    for (int t = 0; t < 5 && t < grant_log.size(); t++)
      checkOutput($sformatf("rr_order%0d", t), grant_log[t], order_rr[t]);

    // Fairness: req[1] held, req[3] raised mid-transaction
    @(negedge clk);
    $display("[TB] fairness");
    grant_log.delete();
    applyStimulus(4'b0010);
    wait_grant();
    applyStimulus(4'b1010);
    wait_done(1, e, n);
    wait_done(3, e, n);
    applyStimulus(4'b0010);
    wait_done(1, e, n);
    applyStimulus(4'b0000);
    checkOutput("fair_count", grant_log.size(), 32'd3);
    for (int t = 0; t < 3 && t < grant_log.size(); t++)
      checkOutput($sformatf("fair_order%0d", t), grant_log[t], order_fr[t]);

    // Master stuck ready
    @(negedge clk);
    $display("[TB] stuck ready");
    master_stuck = 1'b1;
    op_addr[0] = 7'h2A; op_wdata[0] = 8'h06; req_rw[0] = 1'b0;
    applyStimulus(4'b0001);
    wait_done(0, e, n);
    checkOutput("stuck_err", e, 32'h1);
    checkOutput("stuck_en_cycles", n, 32'd9);
    applyStimulus(4'b0000);
    master_stuck = 1'b0;

    // Reset in the middle of WAIT_DONE
    @(negedge clk);
    $display("[TB] reset mid-transaction");
    master_low = 6;
    applyStimulus(4'b0001);
    begin
      bit reached = 1'b0;
      for (int k = 0; k < 10 && !reached; k++) begin
        @(negedge clk);
        if (busy && !m_enable && !m_ready) reached = 1'b1;
      end
      checkOutput("reach_wait_done", reached, 32'h1);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", {gnt, done, busy, m_enable}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0011;
    wait_grant();
    checkOutput("post_rst_gnt", gnt, 32'h1);
    wait_done(0, e, n);
    applyStimulus(4'b0000);
    master_low = 3;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
